// File: rtl/axi_stream_slv_if.sv
// Framed stream input plus the random-access read port of the ping-pong frame buffer.
// The master side is the producer/consumer pair; the slave side is the receiver.
interface axi_stream_slv_if #(
    parameter int DATA_WIDTH = 64,
    parameter int AW         = 2
);
    logic                  vld;
    logic                  sof;
    logic                  eof;
    logic [DATA_WIDTH-1:0] din;
    logic                  frm_rdy;
    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  frm_ack;

    modport master (
        output vld, sof, eof, din, rd_addr, frm_ack,
        input  frm_rdy, rd_data
    );

    modport slave (
        input  vld, sof, eof, din, rd_addr, frm_ack,
        output frm_rdy, rd_data
    );
endinterface

// File: rtl/axi_stream_slv.sv
// Receives fixed-length sof/eof framed words into a two-bank ping-pong buffer and
// exposes each committed frame through a registered random-access read port.
module axi_stream_slv #(
    parameter int DATA_WIDTH  = 64,
    parameter int FRAME_WORDS = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_stream_slv_if.slave      s,
    output logic                 err_sof,
    output logic                 err_len,
    output logic                 err_ovf,
    output logic [CNT_WIDTH-1:0] frm_cnt
);
    localparam int AW  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int WCW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t                state_reg, state_next;
    logic [WCW-1:0]        wcnt_reg, wcnt_next, wcnt_inc;
    logic                  wr_bank_reg, rd_bank_reg;
    logic                  full_reg [2];
    logic [CNT_WIDTH-1:0]  frm_cnt_reg;
    logic                  err_sof_reg, err_len_reg, err_ovf_reg;
    logic                  err_sof_next, err_len_next, err_ovf_next;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  we, commit, ack, frm_rdy;
    logic [AW-1:0]         waddr;

    logic [DATA_WIDTH-1:0] mem [0:(2 << AW) - 1];

    assign wcnt_inc = wcnt_reg + WCW'(1);
    assign frm_rdy  = full_reg[rd_bank_reg];
    assign ack      = s.frm_ack && frm_rdy;

    always_comb begin
        state_next   = state_reg;
        wcnt_next    = wcnt_reg;
        we           = 1'b0;
        waddr        = wcnt_reg[AW-1:0];
        commit       = 1'b0;
        err_sof_next = 1'b0;
        err_len_next = 1'b0;
        err_ovf_next = 1'b0;
        if (s.vld) begin
            if (s.sof && state_reg == RECV)
                err_sof_next = 1'b1;
            if (s.sof && state_reg != RECV && full_reg[wr_bank_reg]) begin
                err_ovf_next = 1'b1;
                state_next   = s.eof ? IDLE : DROP;
            end else if (s.sof) begin
                // New frame (or restart): word 0 always lands in the free write bank
                we         = 1'b1;
                waddr      = '0;
                wcnt_next  = WCW'(1);
                state_next = RECV;
                if (s.eof) begin
                    state_next = IDLE;
                    if (FRAME_WORDS == 1)
                        commit = 1'b1;
                    else
                        err_len_next = 1'b1;
                end
            end else begin
                case (state_reg)
                    RECV: begin
                        if (s.eof) begin
                            state_next = IDLE;
                            if (wcnt_inc == WCW'(FRAME_WORDS)) begin
                                we     = 1'b1;
                                commit = 1'b1;
                            end else begin
                                err_len_next = 1'b1;
                            end
                        end else if (wcnt_reg < WCW'(FRAME_WORDS)) begin
                            we        = 1'b1;
                            wcnt_next = wcnt_inc;
                        end else begin
                            err_len_next = 1'b1;
                            state_next   = DROP;
                        end
                    end
                    DROP: begin
                        if (s.eof)
                            state_next = IDLE;
                    end
                    default: err_sof_next = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            wcnt_reg    <= '0;
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            frm_cnt_reg <= '0;
            err_sof_reg <= 1'b0;
            err_len_reg <= 1'b0;
            err_ovf_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wcnt_reg    <= wcnt_next;
            err_sof_reg <= err_sof_next;
            err_len_reg <= err_len_next;
            err_ovf_reg <= err_ovf_next;
            if (commit) begin
                wr_bank_reg <= ~wr_bank_reg;
                frm_cnt_reg <= frm_cnt_reg + CNT_WIDTH'(1);
            end
            if (ack)
                rd_bank_reg <= ~rd_bank_reg;
        end
    end

    // Commit and ack always target different banks, so each flag sees at most one
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                full_reg[gi] <= 1'b0;
            else if (commit && wr_bank_reg == 1'(gi))
                full_reg[gi] <= 1'b1;
            else if (ack && rd_bank_reg == 1'(gi))
                full_reg[gi] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[{wr_bank_reg, waddr}] <= s.din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_data_reg <= '0;
        else if (frm_rdy)
            rd_data_reg <= mem[{rd_bank_reg, s.rd_addr}];
    end

    assign s.frm_rdy = frm_rdy;
    assign s.rd_data = rd_data_reg;
    assign err_sof   = err_sof_reg;
    assign err_len   = err_len_reg;
    assign err_ovf   = err_ovf_reg;
    assign frm_cnt   = frm_cnt_reg;
endmodule

// File: tb/tb_axi_stream_slv.sv
// Directed bench for axi_stream_slv: framing, ping-pong banking, error pulses,
// simultaneous commit/ack and asynchronous reset mid-frame.
module tb_axi_stream_slv;
    localparam int DW = 64;
    localparam int FW = 4;
    localparam int CW = 16;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          err_sof, err_len, err_ovf;
    logic [CW-1:0] frm_cnt;
    int            n_cmp = 0;
    int            n_bad = 0;

    axi_stream_slv_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

    axi_stream_slv #(.DATA_WIDTH(DW), .FRAME_WORDS(FW), .CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .s       (bus),
        .err_sof (err_sof),
        .err_len (err_len),
        .err_ovf (err_ovf),
        .frm_cnt (frm_cnt)
    );

    always #5 clk = ~clk;

    logic [63:0] f1 [4] = '{64'h0002_3332_3141_0004, 64'hFFFF_FF35_000F_0040,
                            64'hFFFF_FFFF_FFFF_0002, 64'h3035_4100_04FF_FFFF};
    logic [63:0] f2 [4] = '{64'h2222_0000_0000_0000, 64'h2222_0000_0000_0001,
                            64'h2222_0000_0000_0002, 64'h2222_0000_0000_0003};
    logic [63:0] fx [4] = '{64'hDEAD_0000_0000_0000, 64'hDEAD_0000_0000_0001,
                            64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0003};
    logic [63:0] f3 [4] = '{64'h3333_0000_0000_00A0, 64'h3333_0000_0000_00A1,
                            64'h3333_0000_0000_00A2, 64'h3333_0000_0000_00A3};
    logic [63:0] f5 [4] = '{64'h5555_0000_0000_0050, 64'h5555_0000_0000_0051,
                            64'h5555_0000_0000_0052, 64'h5555_0000_0000_0053};
    logic [63:0] f6 [4] = '{64'h6666_0000_0000_0060, 64'h6666_0000_0000_0061,
                            64'h6666_0000_0000_0062, 64'h6666_0000_0000_0063};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-20s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_err(input string tag, input logic es, input logic el, input logic eo);
        check({tag, "/err_sof"}, 64'(err_sof), 64'(es));
        check({tag, "/err_len"}, 64'(err_len), 64'(el));
        check({tag, "/err_ovf"}, 64'(err_ovf), 64'(eo));
    endtask

    // One accepted word; inputs return to idle right after the edge
    task automatic word(input logic s, input logic e, input logic [63:0] d);
        bus.vld = 1'b1;
        bus.sof = s;
        bus.eof = e;
        bus.din = d;
        tick();
        bus.vld = 1'b0;
        bus.sof = 1'b0;
        bus.eof = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] f [4]);
        word(1'b1, 1'b0, f[0]);
        word(1'b0, 1'b0, f[1]);
        word(1'b0, 1'b0, f[2]);
        word(1'b0, 1'b1, f[3]);
    endtask

    task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [63:0] exp);
        bus.rd_addr = a;
        tick();
        check(tag, bus.rd_data, exp);
    endtask

    task automatic do_ack();
        bus.frm_ack = 1'b1;
        tick();
        bus.frm_ack = 1'b0;
    endtask

    initial begin
        bus.vld = 1'b0; bus.sof = 1'b0; bus.eof = 1'b0; bus.din = '0;
        bus.rd_addr = '0; bus.frm_ack = 1'b0;

        // Reset state
        tick(); tick();
        check("rst/frm_rdy", 64'(bus.frm_rdy), 64'd0);
        check("rst/rd_data", bus.rd_data, 64'd0);
        check("rst/frm_cnt", 64'(frm_cnt), 64'd0);
        check_err("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        // 1: single good frame, read word 2
        send_frame(f1);
        check("t1/frm_rdy", 64'(bus.frm_rdy), 64'd1);
        check("t1/frm_cnt", 64'(frm_cnt), 64'd1);
        check_err("t1", 1'b0, 1'b0, 1'b0);
        read_chk("t1/rd2", 2'd2, 64'hFFFF_FFFF_FFFF_0002);
        read_chk("t1/rd0", 2'd0, 64'h0002_3332_3141_0004);

        // 2: both banks filled, third frame overflows and is dropped
        send_frame(f2);
        check("t2/frm_cnt2", 64'(frm_cnt), 64'd2);
        word(1'b1, 1'b0, fx[0]);
        check_err("t2/ovf", 1'b0, 1'b0, 1'b1);
        word(1'b0, 1'b0, fx[1]);
        check_err("t2/drop", 1'b0, 1'b0, 1'b0);
        word(1'b0, 1'b0, fx[2]);
        word(1'b0, 1'b1, fx[3]);
        check_err("t2/dropeof", 1'b0, 1'b0, 1'b0);
        check("t2/frm_cnt_ovf", 64'(frm_cnt), 64'd2);
        do_ack();
        check("t2/rdy_after_ack", 64'(bus.frm_rdy), 64'd1);
        read_chk("t2/rd1", 2'd1, f2[1]);
        do_ack();
        check("t2/rdy_empty", 64'(bus.frm_rdy), 64'd0);
        read_chk("t2/hold", 2'd3, f2[1]);

        // 3: short frame, then long frame, then good frame
        word(1'b1, 1'b0, fx[0]);
        word(1'b0, 1'b0, fx[1]);
        word(1'b0, 1'b1, fx[2]);
        check_err("t3/short", 1'b0, 1'b1, 1'b0);
        check("t3/cnt_short", 64'(frm_cnt), 64'd2);
        check("t3/rdy_short", 64'(bus.frm_rdy), 64'd0);
        word(1'b1, 1'b0, fx[0]);
        word(1'b0, 1'b0, fx[1]);
        word(1'b0, 1'b0, fx[2]);
        word(1'b0, 1'b0, fx[3]);
        check_err("t3/long_w3", 1'b0, 1'b0, 1'b0);
        word(1'b0, 1'b1, fx[0]);
        check_err("t3/long_w4", 1'b0, 1'b1, 1'b0);
        check("t3/cnt_long", 64'(frm_cnt), 64'd2);
        send_frame(f3);
        check("t3/cnt_good", 64'(frm_cnt), 64'd3);
        check("t3/rdy_good", 64'(bus.frm_rdy), 64'd1);
        read_chk("t3/rd3", 2'd3, f3[3]);
        do_ack();
        check("t3/rdy_ack", 64'(bus.frm_rdy), 64'd0);

        // 4: stray word, then sof restart inside a frame
        word(1'b0, 1'b0, fx[0]);
        check_err("t4/stray", 1'b1, 1'b0, 1'b0);
        tick();
        check_err("t4/pulse_end", 1'b0, 1'b0, 1'b0);
        word(1'b1, 1'b0, fx[1]);
        word(1'b0, 1'b0, fx[2]);
        word(1'b1, 1'b0, f5[3]);
        check_err("t4/restart", 1'b1, 1'b0, 1'b0);
        word(1'b0, 1'b0, f6[1]);
        word(1'b0, 1'b0, f6[2]);
        word(1'b0, 1'b1, f6[3]);
        check_err("t4/commit", 1'b0, 1'b0, 1'b0);
        check("t4/cnt", 64'(frm_cnt), 64'd4);
        check("t4/rdy", 64'(bus.frm_rdy), 64'd1);
        read_chk("t4/rd0", 2'd0, f5[3]);
        read_chk("t4/rd1", 2'd1, f6[1]);

        // 5: ack of bank 1 coincides with commit into bank 0
        word(1'b1, 1'b0, f5[0]);
        word(1'b0, 1'b0, f5[1]);
        word(1'b0, 1'b0, f5[2]);
        bus.frm_ack = 1'b1;
        word(1'b0, 1'b1, f5[3]);
        bus.frm_ack = 1'b0;
        check("t5/rdy", 64'(bus.frm_rdy), 64'd1);
        check("t5/cnt", 64'(frm_cnt), 64'd5);
        read_chk("t5/rd2", 2'd2, f5[2]);
        do_ack();
        check("t5/rdy_ack", 64'(bus.frm_rdy), 64'd0);

        // 6: asynchronous reset with two words of a frame received
        word(1'b1, 1'b0, fx[0]);
        word(1'b0, 1'b0, fx[1]);
        #2 rst = 1'b0;
        #1;
        check("t6/cnt_async", 64'(frm_cnt), 64'd0);
        check("t6/rd_async", bus.rd_data, 64'd0);
        check("t6/rdy_async", 64'(bus.frm_rdy), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        send_frame(f6);
        check("t6/cnt", 64'(frm_cnt), 64'd1);
        check("t6/rdy", 64'(bus.frm_rdy), 64'd1);
        check_err("t6", 1'b0, 1'b0, 1'b0);
        read_chk("t6/rd0", 2'd0, f6[0]);
        read_chk("t6/rd3", 2'd3, f6[3]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
